// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mips_defs                                                             |
// | Opcode/funct encodings and access-size helpers shared by the M stage. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_BYTE = 2'd1,
        ACC_HALF = 2'd2,
        ACC_WORD = 2'd3
    } acc_size_e;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    // ALU-immediate group (addi..lui) all occupy opcodes 0x08-0x0F.
    function automatic logic is_alu_imm(input logic [5:0] op);
        return op[5:3] == 3'b001;
    endfunction

    function automatic acc_size_e store_size(input logic [5:0] op);
        acc_size_e s;
        case (op)
            OP_SW:   s = ACC_WORD;
            OP_SH:   s = ACC_HALF;
            OP_SB:   s = ACC_BYTE;
            default: s = ACC_NONE;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_dm_ext.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dm_ext                                                                |
// | Load lane select and sign/zero extension of a data-memory word.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module dm_ext
    import mips_defs::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [5:0]  opcode,
    output logic [31:0] ext
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_half = addr[1] ? word[31:16] : word[15:0];
        case (addr)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
    end

    // Non-load opcodes pass the raw word; the W stage ignores it.
    always_comb begin
        ext = word;
        case (opcode)
            OP_LH:   ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  ext = {16'h0000, w_half};
            OP_LB:   ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  ext = {24'h000000, w_byte};
            default: ext = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_wb_stage                                                          |
// | M-stage data memory, M/W pipeline register and M hazard export.      |
// | Optional store trace enabled by defining MEM_STORE_LOG_EN.            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mem_wb_stage
    import mips_defs::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_M,
    input  logic [31:0] PC_M,
    input  logic [31:0] PC8_M,
    input  logic [31:0] AO_M,
    input  logic [31:0] rt_M,
    output logic [3:0]  tnew_M,
    output logic [4:0]  writereg_M,
    output logic [31:0] writedata_M,
    output logic [31:0] IR_W,
    output logic [31:0] PC_W,
    output logic [31:0] PC8_W,
    output logic [31:0] AO_W,
    output logic [31:0] DR_W,
    output logic [4:0]  writereg_W
);

    logic [31:0] r_mem [0:MEM_WORDS-1];

    logic [5:0]    w_op;
    logic [5:0]    w_funct;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rdata;
    logic [31:0]   w_wdata;
    logic [31:0]   w_merged;
    logic [31:0]   w_ext;
    logic [3:0]    w_be;
    logic          w_is_jalr;

    assign w_op      = IR_M[31:26];
    assign w_funct   = IR_M[5:0];
    assign w_idx     = AO_M[AW+1:2];
    assign w_rdata   = r_mem[w_idx];
    assign w_is_jalr = (w_op == OP_RTYPE) && (w_funct == FN_JALR);

    // Hazard export
    assign tnew_M      = is_load(w_op) ? 4'd1 : 4'd0;
    assign writedata_M = ((w_op == OP_JAL) || w_is_jalr) ? PC8_M : AO_M;

    always_comb begin
        writereg_M = 5'd0;
        if (w_op == OP_RTYPE) begin
            writereg_M = (w_funct == FN_JR) ? 5'd0 : IR_M[15:11];
        end else if (w_op == OP_JAL) begin
            writereg_M = REG_RA;
        end else if (is_load(w_op) || is_alu_imm(w_op)) begin
            writereg_M = IR_M[20:16];
        end
    end

    // Store data is replicated across lanes; the byte enables pick the lane.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = rt_M;
        case (store_size(w_op))
            ACC_WORD: w_be = 4'b1111;
            ACC_HALF: begin
                w_be    = AO_M[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{rt_M[15:0]}};
            end
            ACC_BYTE: begin
                w_be    = 4'b0001 << AO_M[1:0];
                w_wdata = {4{rt_M[7:0]}};
            end
            default: w_be = 4'b0000;
        endcase
    end

    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            assign w_merged[8*i +: 8] = w_be[i] ? w_wdata[8*i +: 8] : w_rdata[8*i +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (|w_be) begin
            r_mem[w_idx] <= w_merged;
`ifdef MEM_STORE_LOG_EN
            $display("%d@%h: *%h <= %h", $time, PC_M, {AO_M[31:2], 2'b00}, w_merged);
`endif
        end
    end

    dm_ext u_dm_ext (
        .word   (w_rdata),
        .addr   (AO_M[1:0]),
        .opcode (w_op),
        .ext    (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            IR_W       <= 32'h0;
            PC_W       <= 32'h0;
            PC8_W      <= 32'h0;
            AO_W       <= 32'h0;
            DR_W       <= 32'h0;
            writereg_W <= 5'd0;
        end else begin
            IR_W       <= IR_M;
            PC_W       <= PC_M;
            PC8_W      <= PC8_M;
            AO_W       <= AO_M;
            DR_W       <= w_ext;
            writereg_W <= writereg_M;
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- M-stage data memory plus the M/W pipeline register of the five-stage MIPS pipeline, directly downstream of the E/M register.
- Performs word, halfword and byte stores, and loads with sign or zero extension, on the address and store data from E/M.
- Latches the results for the W stage.
- Exports M-stage hazard info (tnew, writereg, writedata) to the forwarding and stall unit.

Parameters:
- MEM_WORDS, 1024, data memory depth in 32-bit words (4 KiB); power of two.
- AW, 10, word-index width, equal to log2(MEM_WORDS).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- IR_M  in  32  instruction in M stage.
- PC_M  in  32  PC of that instruction.
- PC8_M  in  32  PC+8, the link value.
- AO_M  in  32  ALU result; the memory byte address for loads and stores.
- rt_M  in  32  store data, already forwarded.
- tnew_M  out  4  cycles until this stage's result is ready: 1 for loads, 0 otherwise.
- writereg_M  out  5  destination register of the M-stage instruction; 0 if none.
- writedata_M  out  32  forwardable value: PC8_M for jal/jalr, else AO_M.
- IR_W, PC_W, PC8_W, AO_W  out  32 each  registered copies of IR_M, PC_M, PC8_M and AO_M.
- DR_W  out  32  registered load result, already extended.
- writereg_W  out  5  registered writereg_M.

Behaviour:
- Opcodes decoded:
  - lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24.
  - sw 0x2B, sh 0x29, sb 0x28.
  - jal 0x03; R-type 0x00, with funct 0x09 = jalr and 0x08 = jr.
- Memory indexing:
  - word index = AO_M[AW+1:2]; upper address bits ignored, so out-of-range addresses wrap modulo 4*MEM_WORDS.
  - No alignment trap: sw ignores AO_M[1:0]; sh ignores AO_M[0].
- Stores (rising edge, not in reset):
  - sw writes the whole word.
  - sh writes rt_M[15:0] to halfword AO_M[1] (0 = bits 15:0, 1 = bits 31:16).
  - sb writes rt_M[7:0] to byte lane AO_M[1:0] (lane 0 = bits 7:0).
  - Other bytes of the word are unchanged.
- Loads:
  - Combinational read of the current word.
  - The lane is selected the same way as for stores, then sign-extended (lh, lb) or zero-extended (lhu, lbu).
  - DR_W latches the extended value at the edge.
  - For non-loads DR_W latches the raw word; this is don't-care downstream.
- Read-during-write: there is no same-cycle load and store in one stage. A load that follows a store to the same word sees the new data.
- writereg_M:
  - R-type except jr → rd (IR[15:11]).
  - jal → 31; jalr → rd.
  - Loads, lui, ori, addiu and other ALU-immediate ops (opcodes 0x08–0x0F) → rt.
  - Otherwise 0.
  - Register 0 is never reported as a real destination; consumers ignore it.
- tnew_M: 1 for the five load opcodes, else 0. The W stage implies tnew 0.
- Pipeline register: IR_W, PC_W, PC8_W, AO_W, DR_W and writereg_W load every clock. No stall or flush input; the M stage never stalls.
- Reset (synchronous):
  - All W outputs become 0 (IR_W = 0 is a nop).
  - All MEM_WORDS words clear to 0 over one cycle.
  - A store presented during the reset cycle is discarded.
- Reset mid-stream: the instruction in M during reset is lost; the W side shows a nop on the following cycle.

Optional Feature:
- Macro MEM_STORE_LOG_EN.
- When defined: each committed store issues $display("%d@%h: *%h <= %h", $time, PC_M, {AO_M[31:2],2'b00}, merged_word), where merged_word is the full word after byte merging. Used for comparison against the reference simulator log.
- When undefined: no display statements are compiled and behaviour is otherwise identical.

Decomposition:
- Package mips_defs:
  - opcode and funct localparams (OP_LW, OP_SW, OP_SH, OP_SB, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_JAL, OP_RTYPE, FN_JR, FN_JALR).
  - REG_RA = 31.
- One sub-module, dm_ext: combinational lane select and extension.
  - Inputs: word, addr[1:0], opcode.
  - Output: 32-bit extended value.

Test Plan:
- sw 0x12345678 to 0x0000_0010, then lw from 0x10 → DR_W = 0x12345678 one cycle after lw enters M. tnew_M = 1 and writereg_M = rt while lw is in M.
- After that word is stored, sb 0xAB at 0x11 then lw 0x10 → 0x1234AB78; sh 0xBEEF at 0x12 then lw → 0xBEEFAB78.
- Word 0x80FF7F01 at 0x20:
  - lb 0x20 → 0x00000001; lb 0x23 → 0xFFFFFF80.
  - lbu 0x23 → 0x00000080.
  - lh 0x22 → 0xFFFF80FF; lhu 0x22 → 0x000080FF.
- jal with PC_M = 0x3000 → writereg_M = 31, writedata_M = 0x3008, tnew_M = 0. Next cycle PC8_W = 0x3008 and writereg_W = 31.
- Address wrap: sw to 0x0000_1004 with MEM_WORDS = 1024 → lw 0x4 returns the same data.
- Mid-stream reset: store then reset for 1 cycle.
  - All W outputs read 0.
  - lw of any previously written address returns 0.
  - A sw held during the reset cycle is not committed.
